// File: rtl/poly_ring_mul.sv
// -----------------------------------------------------------------------------
// poly_ring_mul
//   Sequential schoolbook multiplier for polynomials over Z_Q, reduced either
//   negacyclically (x^N = -1) or cyclically (x^N = +1). One coefficient
//   multiply-accumulate is done per cycle, so a product takes N*N cycles.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a_i/b_i/mode_i is valid
//   in_ready   high in IDLE; operands are taken on an edge with both high
//   a_i, b_i   N coefficients of CW bits, coefficient k at [k*CW +: CW]
//   mode_i     0 = negacyclic ring, 1 = cyclic ring
//   out_valid  r_o holds a completed product (DONE state)
//   out_ready  consumer takes r_o; the block returns to IDLE on that edge
//   r_o        product, packed like a_i, every coefficient in [0, Q-1]
//   busy       high while multiplying (CALC state)
//
// Parameters: N >= 2 coefficients, modulus Q >= 2, width CW with 2^CW > Q.
// -----------------------------------------------------------------------------
module poly_ring_mul #(
  parameter int N  = 4,
  parameter int Q  = 17,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*CW-1:0] a_i,
  input  logic [N*CW-1:0] b_i,
  input  logic            mode_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*CW-1:0] r_o,
  output logic            busy
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * CW;   // full product width
  localparam int AW = CW + 1;   // holds acc + Q - p < 2Q without overflow

  localparam logic [CW-1:0] QC   = CW'(Q);
  localparam logic [PW-1:0] QP   = PW'(Q);
  localparam logic [AW-1:0] QA   = AW'(Q);
  localparam logic [IW:0]   NI   = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   a_q   [N];
  logic [CW-1:0]   a_d   [N];
  logic [CW-1:0]   b_q   [N];
  logic [CW-1:0]   b_d   [N];
  logic [CW-1:0]   acc_q [N];
  logic [CW-1:0]   acc_d [N];
  logic            mode_q, mode_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [N*CW-1:0] r_q, r_d;

  // Datapath for the current (i, j) term.
  logic [PW-1:0]   prod;
  logic [CW-1:0]   p;
  logic [IW:0]     idx_sum;
  logic            wrap;
  logic [IW-1:0]   k;
  logic [AW-1:0]   sum;
  logic [CW-1:0]   acc_new;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    prod    = PW'(a_q[i_q]) * PW'(b_q[j_q]);
    p       = CW'(prod % QP);
    idx_sum = {1'b0, i_q} + {1'b0, j_q};
    wrap    = (idx_sum >= NI);
    k       = wrap ? IW'(idx_sum - NI) : IW'(idx_sum);
    // Subtraction is done as + (Q - p) so everything stays unsigned; p < Q
    // keeps Q - p positive and the sum below 2Q, so one conditional
    // subtract fully reduces it.
    if (wrap && !mode_q) begin
      sum = {1'b0, acc_q[k]} + QA - {1'b0, p};
    end else begin
      sum = {1'b0, acc_q[k]} + {1'b0, p};
    end
    acc_new = CW'((sum >= QA) ? sum - QA : sum);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    r_d     = r_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int c = 0; c < N; c++) begin
            // Inputs may exceed Q-1; reduce once here so the MAC only ever
            // sees canonical residues.
            a_d[c]   = a_i[c*CW +: CW] % QC;
            b_d[c]   = b_i[c*CW +: CW] % QC;
            acc_d[c] = '0;
          end
          mode_d  = mode_i;
          i_d     = '0;
          j_d     = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        acc_d[k] = acc_new;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = S_DONE;
            // The last term is still in flight, so the result is taken from
            // the accumulators with this cycle's update merged in.
            for (int c = 0; c < N; c++) begin
              r_d[c*CW +: CW] = (IW'(c) == k) ? acc_new : acc_q[c];
            end
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      // NOTE: the small coefficient arrays are reset element by element; an
      // aborted product must leave no residue in the accumulators, and the
      // operand copies are cleared as well so the state after reset is fully
      // defined.
      for (int c = 0; c < N; c++) begin
        a_q[c]   <= '0;
        b_q[c]   <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC);
  assign out_valid = (state_q == S_DONE);
  assign r_o       = r_q;

endmodule

// File: tb/tb_poly_ring_mul.sv
// -----------------------------------------------------------------------------
// tb_poly_ring_mul
//   Self-checking bench for poly_ring_mul (N=4, Q=17, CW=5): directed ring
//   products, backpressure, reset in the middle of a product, then random
//   operands compared against a plain-arithmetic convolution model.
// -----------------------------------------------------------------------------
module tb_poly_ring_mul;

  localparam int N  = 4;
  localparam int Q  = 17;
  localparam int CW = 5;
  localparam int W  = N * CW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         mode_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r_o;
  logic         busy;

  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] last_r;

  always #5 clk = ~clk;

  poly_ring_mul #(.N(N), .Q(Q), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .mode_i    (mode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_o       (r_o),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
    pack = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  // Ring product by direct convolution: the term a_i*b_j lands on x^((i+j) mod N)
  // and flips sign when it wraps past x^N in the negacyclic ring.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m);
    int res [N];
    int ai, bj, t, kk;
    for (int k = 0; k < N; k++) res[k] = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = int'(a[i*CW +: CW]) % Q;
        bj = int'(b[j*CW +: CW]) % Q;
        t  = ai * bj;
        kk = (i + j) % N;
        if ((i + j >= N) && !m) res[kk] = ((res[kk] - t) % Q + Q) % Q;
        else                    res[kk] = (res[kk] + t) % Q;
      end
    end
    model = '0;
    for (int k = 0; k < N; k++) model[k*CW +: CW] = CW'(res[k]);
  endfunction

  task automatic drive_garbage();
    in_valid = 1'($urandom);
    a_i      = W'($urandom);
    b_i      = W'($urandom);
    mode_i   = 1'($urandom);
  endtask

  // Starts on a negedge, runs one full transaction, ends on the negedge after
  // the out_ready edge with the block back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] exp, input int hold, input string tag);
    int cnt;
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "/in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    a_i       = a;
    b_i       = b;
    mode_i    = m;
    out_ready = 1'b0;
    @(negedge clk);
    cnt = 1;
    check({tag, "/busy"}, busy, 1);
    check({tag, "/calc_not_ready"}, in_ready, 0);
    check({tag, "/r_retained"}, r_o, last_r);
    while (!out_valid && cnt < 100) begin
      drive_garbage();
      @(negedge clk);
      cnt++;
    end
    check({tag, "/latency"}, cnt, N * N + 1);
    check({tag, "/r_o"}, r_o, exp);
    for (int h = 0; h < hold; h++) begin
      drive_garbage();
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_r"}, r_o, exp);
      check({tag, "/hold_not_ready"}, in_ready, 0);
    end
    // Release with in_valid high: must not be taken on the out_ready edge.
    out_ready = 1'b1;
    drive_garbage();
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "/release_valid"}, out_valid, 0);
    check({tag, "/release_ready"}, in_ready, 1);
    check({tag, "/release_busy"}, busy, 0);
    check({tag, "/release_r"}, r_o, exp);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    last_r    = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rm;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    mode_i    = 1'b0;
    out_ready = 1'b0;
    last_r    = '0;
    repeat (2) @(negedge clk);
    check("reset/out_valid", out_valid, 0);
    check("reset/busy", busy, 0);
    check("reset/r_o", r_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset/in_ready", in_ready, 1);

    run_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0, pack(12, 15, 2, 9), 0, "nega");
    run_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1, pack(15, 0, 15, 9), 0, "cyc");
    run_op(pack(0, 0, 0, 1), pack(0, 1, 0, 0), 1'b0, pack(16, 0, 0, 0), 0, "wrap_nega");
    run_op(pack(0, 0, 0, 1), pack(0, 1, 0, 0), 1'b1, pack(1, 0, 0, 0), 0, "wrap_cyc");
    run_op(pack(20, 0, 0, 0), pack(1, 0, 0, 0), 1'b0, pack(3, 0, 0, 0), 0, "reduce");
    run_op(pack(31, 31, 31, 31), pack(31, 31, 31, 31), 1'b0,
           model(pack(31, 31, 31, 31), pack(31, 31, 31, 31), 1'b0), 0, "max_in");
    run_op(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0, pack(12, 15, 2, 9), 10, "backpressure");

    // Reset in the eighth CALC cycle, then a fresh product must be clean.
    in_valid = 1'b1;
    a_i      = pack(1, 2, 3, 4);
    b_i      = pack(5, 6, 7, 8);
    mode_i   = 1'b0;
    repeat (8) @(negedge clk);
    check("abort/busy_before", busy, 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("abort/out_valid", out_valid, 0);
    check("abort/busy", busy, 0);
    check("abort/r_o", r_o, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_r = '0;
    run_op(pack(3, 1, 4, 1), pack(5, 9, 2, 6), 1'b1,
           model(pack(3, 1, 4, 1), pack(5, 9, 2, 6), 1'b1), 0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      run_op(ra, rb, rm, model(ra, rb, rm), int'($urandom_range(0, 3)), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
